mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Optional build macro: MEM_ARB_FAIRNESS_EN (fetch anti-starvation).
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;

    // Access sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Which requester currently owns the memory.
    typedef logic owner_t;
    localparam owner_t OWN_I = 1'b0;
    localparam owner_t OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch (I) and load/store (D).
// Data wins unless the fetch has been starved long enough (starve_hit),
// which is only ever raised when MEM_ARB_FAIRNESS_EN is defined in the top.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   starve_hit,
    output logic   grant_valid,
    output owner_t grant_owner
);

    // Data priority, overridden in favour of a waiting fetch on starve_hit.
    always_comb begin
        grant_valid = if_req | d_req;
        grant_owner = OWN_I;
        if (d_req && !(if_req && starve_hit)) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between IF fetch and MEM load/store.
// Each access: one IDLE grant cycle, MEM_LAT ACCESS cycles, one RESP cycle
// carrying the one-cycle ready pulse.
// Optional build macro: MEM_ARB_FAIRNESS_EN adds a fetch starvation counter;
// without it data requests have strict priority.
//
// Handshake: a requester raises req with its address/data and holds them until
// it samples its ready=1 on a rising edge, dropping req on that same edge. A req
// still high in the following IDLE cycle is a new request. The arbiter works
// from latched copies, so requester inputs may change once granted.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_renable,
    output logic              mem_wenable,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    owner_t           owner;
    logic             we;
    logic             grant_valid;
    owner_t           grant_owner;
    logic             starve_hit;
    logic             grant_load;
    logic             capture;

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .starve_hit  (starve_hit),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == SW'(STARVE_MAX));

    // Count consecutive data grants taken while a fetch was waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_load) begin
            if (grant_owner == OWN_D && if_req) begin
                starve_cnt <= starve_cnt + SW'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic plus the grant/capture strobes for the datapath.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        grant_load = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    grant_load = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    capture    = ~we;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the granted request and capture read data at the end of the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_I;
            we        <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant_load) begin
                owner <= grant_owner;
                if (grant_owner == OWN_D) begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    we        <= d_we;
                end else begin
                    mem_addr <= if_addr;
                    we       <= 1'b0;
                end
            end
            if (capture) begin
                if (owner == OWN_D) begin
                    d_rdata <= mem_rdata;
                end else begin
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

    // Write strobe only in the first ACCESS cycle so a store lands exactly once.
    assign mem_renable = (state == ACCESS) && !we;
    assign mem_wenable = (state == ACCESS) && we && (cnt == CNT_LOAD);

    assign if_ready = (state == RESP) && (owner == OWN_I);
    assign d_ready  = (state == RESP) && (owner == OWN_D);
    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: main instance MEM_LAT=2, STARVE_MAX=2 checked
// every cycle against a transaction-level model, plus a MEM_LAT=1 instance
// for back-to-back fetch timing. Build with or without MEM_ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

  localparam int L  = 2;
  localparam int SM = 2;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 0 (MEM_LAT=2) ----------------
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, if_stall, d_ready, d_stall, mem_renable, mem_wenable;

  // Stand-in memory contents, a fixed function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h0000_1111);
  endfunction

  assign mem_rdata = mem_f(mem_addr);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SM)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ready(d_ready), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_renable(mem_renable),
    .mem_wenable(mem_wenable), .mem_rdata(mem_rdata)
  );

  // ---------------- DUT 1 (MEM_LAT=1) ----------------
  logic        if_req1 = 0, d_req1 = 0, d_we1 = 0;
  logic [31:0] if_addr1 = 0, d_addr1 = 0, d_wdata1 = 0;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ready1, if_stall1, d_ready1, d_stall1, mem_renable1, mem_wenable1;

  assign mem_rdata1 = mem_f(mem_addr1);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1), .if_stall(if_stall1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_rdata(d_rdata1),
    .d_ready(d_ready1), .d_stall(d_stall1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_renable(mem_renable1),
    .mem_wenable(mem_wenable1), .mem_rdata(mem_rdata1)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no ready within cycle budget (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // One access in flight: m_k counts cycles since the grant edge
  // (1..L = memory busy, L+1 = response cycle).
  bit          m_busy = 0;
  int          m_k = 0;
  bit          m_own_d = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
  int          m_starve = 0;
  logic [31:0] exp_q[$];       // model grant order: 1 = D, 0 = I

  function automatic bit pick_i(input bit ir, input bit dr, input int starve);
    return ir && (!dr || (FAIR && starve == SM));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_k <= 0; m_own_d <= 0; m_we <= 0;
      m_addr <= 0; m_wdata <= 0; m_if_rdata <= 0; m_d_rdata <= 0; m_starve <= 0;
    end else if (!m_busy) begin
      if (if_req || d_req) begin
        m_busy <= 1;
        m_k    <= 1;
        if (pick_i(if_req, d_req, m_starve)) begin
          m_own_d <= 0; m_addr <= if_addr; m_we <= 0; m_starve <= 0;
          exp_q.push_back(32'd0);
        end else begin
          m_own_d <= 1; m_addr <= d_addr; m_wdata <= d_wdata; m_we <= d_we;
          m_starve <= if_req ? m_starve + 1 : 0;
          exp_q.push_back(32'd1);
        end
      end
    end else if (m_k == L + 1) begin
      m_busy <= 0;
    end else begin
      if (m_k == L && !m_we) begin
        if (m_own_d) m_d_rdata <= mem_f(m_addr);
        else         m_if_rdata <= mem_f(m_addr);
      end
      m_k <= m_k + 1;
    end
  end

  // ---------------- compare process + monitors ----------------
  int          ren_cnt = 0, wen_cnt = 0, ifstall_cnt = 0, rdy_total = 0;
  logic [31:0] wen_addr = 0, wen_data = 0;
  logic [31:0] rdy_log[$];     // DUT completion order: 1 = D, 0 = I

  always @(negedge clk) begin
    if (chk_on) begin
      bit acc, resp;
      acc  = m_busy && (m_k <= L);
      resp = m_busy && (m_k == L + 1);
      chk("mem_renable", mem_renable, acc && !m_we);
      chk("mem_wenable", mem_wenable, acc && m_we && (m_k == 1));
      chk("mem_addr",    mem_addr,    m_addr);
      chk("mem_wdata",   mem_wdata,   m_wdata);
      chk("if_ready",    if_ready,    resp && !m_own_d);
      chk("d_ready",     d_ready,     resp && m_own_d);
      chk("if_rdata",    if_rdata,    m_if_rdata);
      chk("d_rdata",     d_rdata,     m_d_rdata);
      chk("if_stall",    if_stall,    if_req && !(resp && !m_own_d));
      chk("d_stall",     d_stall,     d_req && !(resp && m_own_d));
      if (mem_renable) ren_cnt++;
      if (mem_wenable) begin wen_cnt++; wen_addr = mem_addr; wen_data = mem_wdata; end
      if (if_stall) ifstall_cnt++;
      if (d_ready)  begin rdy_total++; rdy_log.push_back(32'd1); end
      if (if_ready) begin rdy_total++; rdy_log.push_back(32'd0); end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic data_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, output int lat);
    int t0; bit got;
    got = 0; lat = -1;
    @(posedge clk); #2;
    t0 = cyc; d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (d_ready) begin got = 1; lat = cyc - t0; end
    end
    if (!got) timeout("d_access");
    @(posedge clk); #1;
    d_req = 0;
  endtask

  task automatic fetch_access(input logic [31:0] addr, output int lat);
    int t0; bit got;
    got = 0; lat = -1;
    @(posedge clk); #2;
    t0 = cyc; if_req = 1; if_addr = addr;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_ready) begin got = 1; lat = cyc - t0; end
    end
    if (!got) timeout("if_access");
    @(posedge clk); #1;
    if_req = 0;
  endtask

  task automatic wait_ready1(input string name, output int rc, output logic [31:0] rd);
    bit got;
    got = 0; rc = -1; rd = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_ready1) begin got = 1; rc = cyc; rd = if_rdata1; end
    end
    if (!got) timeout(name);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int lat_d, lat_i, t0, t1, r1, r2, rdy_before, wen_before;
    logic [31:0] rd1, rd2;
    logic [31:0] exp_seq[6];

    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    @(posedge clk); #2 rst = 0;

    // Reset state.
    @(negedge clk);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_en", {mem_renable, mem_wenable}, 2'b00);
    chk("rst_dut1_rdata", if_rdata1, 0);

    // Load from 0x40.
    ren_cnt = 0;
    data_access(1'b0, 32'h40, 32'h0, lat_d);
    chk("load_latency", lat_d, 3);
    chk("load_rdata", d_rdata, 32'hDEADBEEF);
    chk("load_renable_cycles", ren_cnt, 2);

    // Store to 0x80.
    ren_cnt = 0; wen_cnt = 0;
    data_access(1'b1, 32'h80, 32'h12345678, lat_d);
    chk("store_latency", lat_d, 3);
    chk("store_wen_cycles", wen_cnt, 1);
    chk("store_wen_addr", wen_addr, 32'h80);
    chk("store_wen_data", wen_data, 32'h12345678);
    chk("store_no_read", ren_cnt, 0);
    chk("store_rdata_kept", d_rdata, 32'hDEADBEEF);

    // Simultaneous fetch 0x0 and load 0x10: data first.
    ifstall_cnt = 0;
    fork
      data_access(1'b0, 32'h10, 32'h0, lat_d);
      fetch_access(32'h0, lat_i);
    join
    chk("simul_d_latency", lat_d, 3);
    chk("simul_i_latency", lat_i, 7);
    chk("simul_if_stall_cycles", ifstall_cnt, 7);
    chk("simul_if_rdata", if_rdata, 32'h5A5A1111);
    chk("simul_d_rdata", d_rdata, 32'h5A5A1121);

    // Reset during the second ACCESS cycle of a store.
    wen_before = wen_cnt;
    @(posedge clk); #2;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1; d_req = 0;
    @(posedge clk); #2;
    rst = 0;
    rdy_before = rdy_total;
    @(negedge clk);
    chk("midrst_outputs",
        {if_ready, d_ready, if_stall, d_stall, mem_renable, mem_wenable}, 6'b0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_d_rdata", d_rdata, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    repeat (6) @(negedge clk);
    chk("midrst_no_ready", rdy_total - rdy_before, 0);
    chk("midrst_single_write", wen_cnt - wen_before, 1);

    // Both requesters held high: grant order.
    exp_q.delete();
    rdy_log.delete();
    rdy_before = rdy_total;
    @(posedge clk); #2;
    if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h104;
    for (int i = 0; i < 60 && (rdy_total - rdy_before) < 6; i++) @(negedge clk);
    if ((rdy_total - rdy_before) < 6) timeout("fair_grants");
    @(posedge clk); #1;
    if_req = 0; d_req = 0;
    if (FAIR) exp_seq = '{32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 32'd0};
    else      exp_seq = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("grant_dut_%0d", i), (i < rdy_log.size()) ? rdy_log[i] : 32'hFFFF_FFFF, exp_seq[i]);
      chk($sformatf("grant_model_%0d", i), (i < exp_q.size()) ? exp_q[i] : 32'hFFFF_FFFF, exp_seq[i]);
    end
    repeat (6) @(posedge clk);

    // MEM_LAT=1 instance: back-to-back fetches at 0x0 and 0x4.
    @(posedge clk); #2;
    t0 = cyc; if_req1 = 1; if_addr1 = 32'h0;
    wait_ready1("lat1_fetch0", r1, rd1);
    @(posedge clk); #1;
    t1 = cyc; if_addr1 = 32'h4;
    wait_ready1("lat1_fetch1", r2, rd2);
    @(posedge clk); #1;
    if_req1 = 0;
    chk("lat1_latency0", r1 - t0, 2);
    chk("lat1_latency1", r2 - t1, 2);
    chk("lat1_spacing", t1 - t0, 3);
    chk("lat1_rdata0", rd1, 32'h5A5A1111);
    chk("lat1_rdata1", rd2, 32'h5A5A1115);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
